// File: rtl/char_scroller.sv
// rtl/char_scroller.sv - loads up to DEPTH 4-bit codes, then scrolls them right-to-left
// across four 7-segment digit codes, one position per TICK_DIV clocks.
module char_scroller #(
   parameter int          TICK_DIV = 25000000,
   parameter int          DEPTH    = 8,
   parameter logic [3:0]  BLANK    = 4'hF
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        clr,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [3:0]  in_code,
   input  logic        in_last,
   output logic [15:0] digits,
   output logic        busy,
   output logic        done
);

   localparam int TW = $clog2(TICK_DIV);
   // len <= 16 and p <= len+2 <= 18, so five bits cover both
   localparam int LW = 5;

   typedef enum logic {LOAD, SCROLL} state_t;

   state_t          state, state_n;
   logic [LW-1:0]   len, len_n;
   logic [LW-1:0]   p, p_n;
   logic [TW-1:0]   tick, tick_n;
   logic [3:0]      chars   [DEPTH];
   logic [3:0]      chars_n [DEPTH];
   logic [15:0]     digits_n;
   logic            done_n;

   assign busy     = (state == SCROLL);
   assign in_ready = (state == LOAD) && !clr && (len < LW'(DEPTH));

   always_comb begin
      state_n = state;
      len_n   = len;
      p_n     = p;
      tick_n  = tick;
      chars_n = chars;
      done_n  = 1'b0;
      if (clr) begin
         state_n = LOAD;
         len_n   = '0;
         p_n     = '0;
         tick_n  = '0;
      end else begin
         case (state)
            LOAD: begin
               if (in_valid && in_ready) begin
                  for (int k = 0; k < DEPTH; k++) begin
                     if (len == LW'(k)) chars_n[k] = in_code;
                  end
                  len_n = len + 1'b1;
                  if (in_last || (len + 1'b1) == LW'(DEPTH)) begin
                     state_n = SCROLL;
                     p_n     = '0;
                     tick_n  = '0;
                  end
               end
            end
            SCROLL: begin
               if (tick == TW'(TICK_DIV - 1)) begin
                  tick_n = '0;
                  if (p == len + LW'(2)) begin
                     done_n  = 1'b1;
                     len_n   = '0;
                     p_n     = '0;
                     state_n = LOAD;
                  end else begin
                     p_n = p + 1'b1;
                  end
               end else begin
                  tick_n = tick + 1'b1;
               end
            end
            default: state_n = LOAD;
         endcase
      end
   end

   // Digits are computed from next-state values so they are correct on the first SCROLL cycle;
   // digit d shows chars[k] when k = p-d and k < len, which keeps stale entries hidden.
   always_comb begin
      digits_n = {4{BLANK}};
      if (state_n == SCROLL) begin
         for (int d = 0; d < 4; d++) begin
            for (int k = 0; k < DEPTH; k++) begin
               if (LW'(k) < len_n && p_n == LW'(k + d)) digits_n[d*4 +: 4] = chars_n[k];
            end
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state  <= LOAD;
         len    <= '0;
         p      <= '0;
         tick   <= '0;
         done   <= 1'b0;
         digits <= {4{BLANK}};
      end else begin
         state  <= state_n;
         len    <= len_n;
         p      <= p_n;
         tick   <= tick_n;
         done   <= done_n;
         digits <= digits_n;
      end
   end

   always_ff @(posedge clk) begin
      chars <= chars_n;
   end

endmodule
